// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter (mem_arb).
//   arb_state_t : arbiter FSM states (idle, access issued, waiting on read data)
//   arb_owner_t : identifies which requester owns the current access
//   ARB_NREQ    : number of requesters sharing the memory
package mem_arb_pkg;

    localparam int ARB_NREQ = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ACC  = 2'd1,
        ARB_WT   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for mem_arb.
// Ports:
//   cpu_elig / dbg_elig : requester is asking and was not granted this cycle
//   rr_pri              : requester that wins when both are eligible
//   win                 : selected requester
//   win_vld             : at least one requester is eligible
// A lone eligible requester always wins regardless of rr_pri.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       cpu_elig,
    input  logic       dbg_elig,
    input  arb_owner_t rr_pri,
    output arb_owner_t win,
    output logic       win_vld
);

    always_comb begin
        win_vld = cpu_elig | dbg_elig;
        if (cpu_elig && dbg_elig) begin
            win = rr_pri;
        end else if (dbg_elig) begin
            win = OWN_DBG;
        end else begin
            win = OWN_CPU;
        end
    end

endmodule

// File: rtl/mem_arb_svamod.sv
// Assertion companion for mem_arb.
// Ports: clk, rst_n, the arbiter state and every mem_arb output (all inputs here).
// Checks: outputs never unknown, state is ARB_IDLE while reset is held, grants and
// read returns are each at most one-hot, and every read grant is followed by exactly
// one rvalid to the same requester RD_LAT cycles after the grant cycle.
module mem_arb_svamod
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input logic              clk,
    input logic              rst_n,
    input arb_state_t        st_r,
    input logic              cpu_gnt,
    input logic              cpu_rvalid,
    input logic [DATA_W-1:0] cpu_rdata,
    input logic              dbg_gnt,
    input logic              dbg_rvalid,
    input logic [DATA_W-1:0] dbg_rdata,
    input logic              mem_en,
    input logic              mem_we,
    input logic [ADDR_W-1:0] mem_addr,
    input logic [DATA_W-1:0] mem_wdata
);

    logic [ARB_NREQ-1:0] gnt_vec;
    logic [ARB_NREQ-1:0] rvld_vec;
    logic [RD_LAT-1:0]   cpu_rd_vld_p;
    logic [RD_LAT-1:0]   dbg_rd_vld_p;

    assign gnt_vec  = {dbg_gnt, cpu_gnt};
    assign rvld_vec = {dbg_rvalid, cpu_rvalid};

    // Read-grant shadow pipes: bit RD_LAT-1 marks the cycle rvalid is due.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rd_vld_p <= '0;
            dbg_rd_vld_p <= '0;
        end else begin
            cpu_rd_vld_p <= RD_LAT'({cpu_rd_vld_p, cpu_gnt & ~mem_we});
            dbg_rd_vld_p <= RD_LAT'({dbg_rd_vld_p, dbg_gnt & ~mem_we});
        end
    end

    a_no_x : assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
                     mem_en, mem_we, mem_addr, mem_wdata}));

    a_rst_idle : assert property (@(posedge clk) !rst_n |-> (st_r == ARB_IDLE));

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_vec));

    a_rvld_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rvld_vec));

    a_cpu_rd_ret : assert property (@(posedge clk) disable iff (!rst_n)
        cpu_rvalid == cpu_rd_vld_p[RD_LAT-1]);

    a_dbg_rd_ret : assert property (@(posedge clk) disable iff (!rst_n)
        dbg_rvalid == dbg_rd_vld_p[RD_LAT-1]);

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter for the single-port data/instruction memory, shared between
// the core (cpu_*) and the debug/program loader (dbg_*).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata          core request, held with attributes until cpu_gnt
//   cpu_gnt                        1-cycle pulse, core access issued to memory
//   cpu_rvalid/cpu_rdata           1-cycle read return, rdata is zero when not valid
//   dbg_*                          same set for the debug port
//   mem_en/we/addr/wdata           registered memory-side request
//   mem_rdata                      memory read data, valid RD_LAT cycles after mem_en
// Configuration macro MEMARB_RR_EN: defined -> round-robin ties (loser of the last
// grant wins the next tie); undefined -> fixed priority, cpu beats dbg.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    arb_state_t        st_r, st_nx;
    arb_owner_t        own_r;
    arb_owner_t        rr_r;
    arb_owner_t        win;
    logic [CNT_W-1:0]  wt_cnt_r, wt_cnt_nx;
    logic              win_vld;
    logic              cpu_elig, dbg_elig;
    logic              arb_slot, grant, rd_ret_nx;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              cpu_gnt_r, dbg_gnt_r, cpu_rvalid_r, dbg_rvalid_r;
    logic              mem_en_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    // A requester being granted this cycle is still holding req; keep it out of
    // this cycle's arbitration so one request is served only once.
    assign cpu_elig = cpu_req & ~cpu_gnt_r;
    assign dbg_elig = dbg_req & ~dbg_gnt_r;

    mem_arb_pick u_pick (
        .cpu_elig (cpu_elig),
        .dbg_elig (dbg_elig),
        .rr_pri   (rr_r),
        .win      (win),
        .win_vld  (win_vld)
    );

    // Arbitration slots: idle, a write access cycle, and the last read-wait cycle.
    assign arb_slot = (st_r == ARB_IDLE)
                    | ((st_r == ARB_ACC) & mem_we_r)
                    | ((st_r == ARB_WT) & (wt_cnt_r == CNT_W'(RD_LAT)));
    assign grant    = arb_slot & win_vld;

    assign win_we    = (win == OWN_DBG) ? dbg_we    : cpu_we;
    assign win_addr  = (win == OWN_DBG) ? dbg_addr  : cpu_addr;
    assign win_wdata = (win == OWN_DBG) ? dbg_wdata : cpu_wdata;

`ifdef MEMARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r <= OWN_CPU;
        end else if (grant) begin
            rr_r <= (win == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end
    end
`else
    assign rr_r = OWN_CPU;
`endif

    always_comb begin
        st_nx     = st_r;
        wt_cnt_nx = wt_cnt_r;
        case (st_r)
            ARB_ACC: begin
                if (!mem_we_r) begin
                    st_nx     = ARB_WT;
                    wt_cnt_nx = CNT_W'(1);
                end
            end
            ARB_WT: begin
                if (wt_cnt_r != CNT_W'(RD_LAT)) begin
                    wt_cnt_nx = wt_cnt_r + CNT_W'(1);
                end
            end
            default: ;
        endcase
        if (arb_slot) begin
            st_nx = grant ? ARB_ACC : ARB_IDLE;
        end
    end

    // Next cycle is the final wait cycle, which is when read data is valid.
    assign rd_ret_nx = (st_nx == ARB_WT) && (wt_cnt_nx == CNT_W'(RD_LAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r         <= ARB_IDLE;
            wt_cnt_r     <= '0;
            own_r        <= OWN_CPU;
            cpu_gnt_r    <= 1'b0;
            dbg_gnt_r    <= 1'b0;
            cpu_rvalid_r <= 1'b0;
            dbg_rvalid_r <= 1'b0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
        end else begin
            st_r         <= st_nx;
            wt_cnt_r     <= wt_cnt_nx;
            cpu_gnt_r    <= grant & (win == OWN_CPU);
            dbg_gnt_r    <= grant & (win == OWN_DBG);
            mem_en_r     <= grant;
            mem_we_r     <= grant & win_we;
            cpu_rvalid_r <= rd_ret_nx & (own_r == OWN_CPU);
            dbg_rvalid_r <= rd_ret_nx & (own_r == OWN_DBG);
            if (grant) begin
                own_r       <= win;
                mem_addr_r  <= win_addr;
                mem_wdata_r <= win_wdata;
            end
        end
    end

    assign cpu_gnt    = cpu_gnt_r;
    assign dbg_gnt    = dbg_gnt_r;
    assign cpu_rvalid = cpu_rvalid_r;
    assign dbg_rvalid = dbg_rvalid_r;
    assign mem_en     = mem_en_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

    // Read data is gated so both rdata buses sit at zero outside their return pulse.
    assign cpu_rdata = cpu_rvalid_r ? mem_rdata : '0;
    assign dbg_rdata = dbg_rvalid_r ? mem_rdata : '0;

    mem_arb_svamod #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_sva (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_r       (st_r),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata)
    );

endmodule

// File: tb/tb_mem_arb.sv
// Testbench for mem_arb: directed scenarios plus randomized traffic, all checked
// against a schedule-based reference model of the arbitration rules.
module tb_mem_arb;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 1;
    localparam int NC     = 4096;
    localparam int NWORDS = 2 ** ADDR_W;

    logic              clk, rst_n;
    logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests, n_fail, cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory behind the arbiter: synchronous write, RD_LAT-deep read pipe.
    logic              load_mem;
    logic [DATA_W-1:0] tbmem  [NWORDS];
    logic [DATA_W-1:0] rd_pipe[RD_LAT];

    function automatic logic [DATA_W-1:0] init_word(input int a);
        if (a == 'h10) return 16'hBEEF;
        return DATA_W'(a * 40503 + 12345);
    endfunction

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < NWORDS; i++) tbmem[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            tbmem[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= tbmem[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Reference model: per-cycle tables of expected outputs, filled in as the
    // arbitration rules grant accesses. free_at is the next cycle an arbitration
    // decision may be taken.
    bit                e_cg[NC], e_dg[NC], e_en[NC], e_we[NC], e_cv[NC], e_dv[NC];
    logic [ADDR_W-1:0] e_addr[NC];
    logic [DATA_W-1:0] e_wd[NC], e_rd[NC];
    logic [DATA_W-1:0] shadow[NWORDS];
    int                free_at;
    bit                tie_dbg;

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            e_cg[i] = 0; e_dg[i] = 0; e_en[i] = 0; e_we[i] = 0; e_cv[i] = 0; e_dv[i] = 0;
            e_addr[i] = '0; e_wd[i] = '0; e_rd[i] = '0;
        end
        cyc     = 0;
        free_at = 0;
        tie_dbg = 0;
    endtask

    task automatic model_step();
        int                t;
        bit                ce, de, wd;
        logic              w_we;
        logic [ADDR_W-1:0] w_a;
        logic [DATA_W-1:0] w_d;
        t = cyc;
        chk("cpu_gnt", cpu_gnt, e_cg[t]);
        chk("dbg_gnt", dbg_gnt, e_dg[t]);
        chk("mem_en", mem_en, e_en[t]);
        chk("mem_we", mem_we, e_we[t]);
        chk("cpu_rvalid", cpu_rvalid, e_cv[t]);
        chk("dbg_rvalid", dbg_rvalid, e_dv[t]);
        if (e_en[t]) chk("mem_addr", mem_addr, e_addr[t]);
        if (e_we[t]) chk("mem_wdata", mem_wdata, e_wd[t]);
        if (e_cv[t]) chk("cpu_rdata", cpu_rdata, e_rd[t]);
        if (e_dv[t]) chk("dbg_rdata", dbg_rdata, e_rd[t]);
        if (t >= free_at) begin
            free_at = t + 1;
            ce = cpu_req && !e_cg[t];
            de = dbg_req && !e_dg[t];
            if (ce || de) begin
                wd   = de && (!ce || tie_dbg);
                w_we = wd ? dbg_we : cpu_we;
                w_a  = wd ? dbg_addr : cpu_addr;
                w_d  = wd ? dbg_wdata : cpu_wdata;
`ifdef MEMARB_RR_EN
                tie_dbg = !wd;
`endif
                if (wd) e_dg[t+1] = 1; else e_cg[t+1] = 1;
                e_en[t+1]   = 1;
                e_we[t+1]   = w_we;
                e_addr[t+1] = w_a;
                e_wd[t+1]   = w_d;
                if (w_we) begin
                    shadow[w_a] = w_d;
                end else begin
                    e_rd[t+1+RD_LAT] = shadow[w_a];
                    if (wd) e_dv[t+1+RD_LAT] = 1; else e_cv[t+1+RD_LAT] = 1;
                    free_at = t + 1 + RD_LAT;
                end
            end
        end
    endtask

    task automatic run_cycle(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                             input logic [DATA_W-1:0] cd, input logic dr, input logic dw,
                             input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
        @(negedge clk);
        model_step();
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) run_cycle(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_cpu_gnt"}, cpu_gnt, 0);
        chk({pfx, "_dbg_gnt"}, dbg_gnt, 0);
        chk({pfx, "_mem_en"}, mem_en, 0);
        chk({pfx, "_mem_we"}, mem_we, 0);
        chk({pfx, "_mem_addr"}, mem_addr, 0);
        chk({pfx, "_mem_wdata"}, mem_wdata, 0);
        chk({pfx, "_cpu_rvalid"}, cpu_rvalid, 0);
        chk({pfx, "_dbg_rvalid"}, dbg_rvalid, 0);
    endtask

    bit                c_pend, d_pend, c_we, d_we;
    logic [ADDR_W-1:0] c_a, d_a;
    logic [DATA_W-1:0] c_d, d_d;
    int                cnt;
    bit                rv_seen;

    initial begin
        clk = 0; rst_n = 1; load_mem = 1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        n_tests = 0; n_fail = 0;
        for (int i = 0; i < NWORDS; i++) shadow[i] = init_word(i);
        model_clear();
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        load_mem = 0;
        rst_n    = 1;
        idle(2);

        // 1: cpu read of 0x10 from idle
        run_cycle(1, 0, 8'h10, '0, 0, 0, '0, '0);
        run_cycle(1, 0, 8'h10, '0, 0, 0, '0, '0);
        chk("t1_cpu_gnt", cpu_gnt, 1);
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_addr", mem_addr, 8'h10);
        run_cycle(0, 0, '0, '0, 0, 0, '0, '0);
        chk("t1_cpu_rvalid", cpu_rvalid, 1);
        chk("t1_cpu_rdata", cpu_rdata, 16'hBEEF);
        chk("t1_dbg_rvalid", dbg_rvalid, 0);
        idle(2);

        // 2: dbg write 0x1234 to 0x20
        run_cycle(0, 0, '0, '0, 1, 1, 8'h20, 16'h1234);
        run_cycle(0, 0, '0, '0, 1, 1, 8'h20, 16'h1234);
        chk("t2_dbg_gnt", dbg_gnt, 1);
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_addr", mem_addr, 8'h20);
        chk("t2_mem_wdata", mem_wdata, 16'h1234);
        run_cycle(0, 0, '0, '0, 0, 0, '0, '0);
        chk("t2_idle_mem_en", mem_en, 0);
        chk("t2_no_rvalid", dbg_rvalid, 0);
        idle(2);

        // 3: both requesters write continuously, four accesses
        for (int k = 0; k < 5; k++)
            run_cycle(k < 4, 1, 8'h30, 16'hA000 + 16'(k), 1, 1, 8'h31, 16'hB000 + 16'(k));
        idle(2);

        // 4: cpu holds req through its gnt, then drops: one access only
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            run_cycle(k < 2, 1, 8'h40, 16'h4444, 0, 0, '0, '0);
            if (cpu_gnt) cnt++;
        end
        chk("t4_one_access", cnt, 1);
        idle(1);

        // 5: async reset while a cpu read is in flight
        run_cycle(1, 0, 8'h10, '0, 0, 0, '0, '0);
        run_cycle(1, 0, 8'h10, '0, 0, 0, '0, '0);
        #2 rst_n = 0;
        cpu_req = 0;
        #1 chk_all_zero("t5_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_clear();
        rv_seen = 0;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            rv_seen = rv_seen | cpu_rvalid | dbg_rvalid;
        end
        chk("t5_no_rvalid", rv_seen, 0);

        // 6: cpu read then dbg read back to back
        run_cycle(1, 0, 8'h10, '0, 0, 0, '0, '0);
        run_cycle(1, 0, 8'h10, '0, 1, 0, 8'h20, '0);
        run_cycle(0, 0, '0, '0, 1, 0, 8'h20, '0);
        chk("t6_cpu_rvalid", cpu_rvalid, 1);
        chk("t6_cpu_rdata", cpu_rdata, 16'hBEEF);
        run_cycle(0, 0, '0, '0, 1, 0, 8'h20, '0);
        chk("t6_dbg_gnt", dbg_gnt, 1);
        run_cycle(0, 0, '0, '0, 0, 0, '0, '0);
        chk("t6_dbg_rvalid", dbg_rvalid, 1);
        chk("t6_dbg_rdata", dbg_rdata, 16'h1234);
        idle(2);

        // Randomized traffic: requests held until granted, occasional abandon.
        c_pend = 0; d_pend = 0;
        c_we = 0; d_we = 0; c_a = '0; d_a = '0; c_d = '0; d_d = '0;
        for (int k = 0; k < 1500; k++) begin
            if (c_pend && e_cg[cyc-1]) c_pend = 0;
            if (d_pend && e_dg[cyc-1]) d_pend = 0;
            if (c_pend && !e_cg[cyc] && $urandom_range(15) == 0) c_pend = 0;
            if (d_pend && !e_dg[cyc] && $urandom_range(15) == 0) d_pend = 0;
            if (!c_pend && $urandom_range(9) < 4) begin
                c_pend = 1; c_we = 1'($urandom_range(1));
                c_a = ADDR_W'($urandom_range(15)); c_d = DATA_W'($urandom);
            end
            if (!d_pend && $urandom_range(9) < 4) begin
                d_pend = 1; d_we = 1'($urandom_range(1));
                d_a = ADDR_W'($urandom_range(15)); d_d = DATA_W'($urandom);
            end
            run_cycle(c_pend, c_we, c_a, c_d, d_pend, d_we, d_a, d_d);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
